// File: rtl/launcher_pkg.sv
// Shared types and widths for the core launch sequencer.
// The state enum is shared so any debug or integration logic decodes the same encoding.
package launcher_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CRST   = 3'd2,
    RUN    = 3'd3,
    REPORT = 3'd4
  } launch_state_t;

  localparam int DM_AW = 8;
  localparam int CYC_W = 16;

endpackage

// File: rtl/core_launcher.sv
// Session sequencer: preloads DMem, holds the core in reset, runs it and reports
// completion or timeout along with the number of execution cycles.
module core_launcher
  import launcher_pkg::*;
#(
  parameter int DM_WORDS   = 256,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [8:0]       load_len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             dm_wen,
  output logic [DM_AW-1:0] dm_addr,
  output logic [7:0]       dm_wdat,
  output logic             core_reset,
  input  logic             core_done,
  output logic             busy,
  output logic             finished,
  output logic             timeout,
  output logic [CYC_W-1:0] cycles
);

  // Length needs one bit beyond the address so a full-memory load is representable.
  localparam int LEN_W = $clog2(DM_WORDS) + 1;
  localparam int RST_W = $clog2(RST_CYCLES + 1);

  launch_state_t    state;
  logic [LEN_W-1:0] len_q;
  logic [DM_AW-1:0] addr_cnt;
  logic [RST_W-1:0] rst_cnt;
  logic             last_byte;
  logic             timeout_hit;
  logic             in_load;

  assign in_load     = (state == LOAD);
  assign last_byte   = (LEN_W'(addr_cnt) == (len_q - LEN_W'(1)));
  assign timeout_hit = (cycles == CYC_W'(TIMEOUT - 1));

  assign busy       = (state != IDLE);
  assign in_ready   = in_load;
  assign dm_wen     = in_load && in_valid;
  assign dm_addr    = in_load ? addr_cnt : '0;
  assign dm_wdat    = in_load ? in_data : '0;
  assign core_reset = (state != RUN);
  assign finished   = (state == REPORT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      addr_cnt <= '0;
      rst_cnt  <= '0;
      cycles   <= '0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= LEN_W'(load_len);
            addr_cnt <= '0;
            rst_cnt  <= '0;
            cycles   <= '0;
            timeout  <= 1'b0;
            state    <= (load_len != 9'd0) ? LOAD : CRST;
          end
        end
        LOAD: begin
          if (in_valid) begin
            addr_cnt <= addr_cnt + 1'b1;
            if (last_byte) state <= CRST;
          end
        end
        // core_done is deliberately ignored here; it may still show the previous run's PC.
        CRST: begin
          if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
            rst_cnt <= '0;
            state   <= RUN;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        RUN: begin
          if (core_done) begin
            state <= REPORT;
          end else if (timeout_hit) begin
            cycles  <= CYC_W'(TIMEOUT);
            timeout <= 1'b1;
            state   <= REPORT;
          end else begin
            cycles <= cycles + 1'b1;
          end
        end
        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/core_launcher.md
# core_launcher

Session sequencer that sits directly upstream of the processor top level. It streams a data-memory image into the core's DMem write port, holds the core in reset while loading, and releases it for execution. It then watches the core's `done` flag, counts execution cycles, and reports completion or timeout. The integrator muxes `dm_*` onto DMem and drives the core's `reset` from `core_reset`.

## Interface
Parameters:
- `DM_WORDS`, 256: data-memory depth in bytes. Address width is 8.
- `RST_CYCLES`, 2: number of cycles `core_reset` is held after loading completes (≥1).
- `TIMEOUT`, 4096: maximum number of RUN cycles before abort (1..65535).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begins a session. Sampled only in IDLE.
- `load_len` in 9: number of bytes to preload (0..DM_WORDS). Latched on `start`.
- `in_valid` in 1: preload byte valid.
- `in_data` in 8: preload byte.
- `in_ready` out 1: block accepts a byte this cycle.
- `dm_wen` out 1: DMem write enable.
- `dm_addr` out 8: DMem write address.
- `dm_wdat` out 8: DMem write data.
- `core_reset` out 1: reset to the core (PC/ALU state).
- `core_done` in 1: core completion flag (PC > 199).
- `busy` out 1: high whenever state is not IDLE.
- `finished` out 1: one-cycle pulse when a session ends.
- `timeout` out 1: session ended by timeout. Sticky until the next accepted `start`.
- `cycles` out 16: RUN cycles elapsed. Holds its value until the next accepted `start`.

## Operation
States: IDLE, LOAD, CRST, RUN, REPORT.

- **IDLE:**
  - Outputs: `core_reset`=1, `in_ready`=0.
  - On `start`: latch `load_len`, clear `addr_cnt`, `cycles` and `timeout`, then:
    - go to LOAD if `load_len`≠0;
    - go to CRST if `load_len`=0.
- **LOAD:**
  - Outputs: `in_ready`=1, `core_reset`=1.
  - Writes: `dm_wen` = `in_valid` (combinational), `dm_addr` = `addr_cnt`, `dm_wdat` = `in_data`.
  - On each accept, `addr_cnt`++.
  - The accept with `addr_cnt` = `load_len`−1 moves to CRST.
  - Accept of the 256th byte: the 8-bit address wraps to 0 but is never used.
- **CRST:**
  - `core_reset`=1 for exactly `RST_CYCLES` cycles, counted by `rst_cnt`.
  - `core_done` is ignored, because it may still reflect the previous run's PC.
  - Then go to RUN.
- **RUN:**
  - `core_reset`=0.
  - Each cycle with `core_done`=0: `cycles`++.
  - `core_done`=1 goes to REPORT; `cycles` is not incremented that cycle.
  - If `core_done`=0 and `cycles` = `TIMEOUT`−1: `cycles` becomes `TIMEOUT`, `timeout` is set, go to REPORT.
  - If `core_done` and the timeout condition coincide, `core_done` wins and `timeout` stays 0.
- **REPORT:**
  - `finished`=1 and `core_reset`=1 for one cycle, then go to IDLE.
- **Outside LOAD:** `dm_wen`=0; `dm_addr` and `dm_wdat` drive 0.
- **`start` handling:** `start` is ignored in every state except IDLE. `start` held high through REPORT relaunches immediately from IDLE on the next cycle.
- **Reset:** `reset` at any point, including mid-LOAD or mid-RUN, returns to IDLE on the next edge. DMem contents written so far are left as-is.

## Timing
- Reset values:
  - state = IDLE; `core_reset`=1.
  - `in_ready`, `dm_wen`, `busy`, `finished`, `timeout` = 0.
  - `dm_addr`=0, `dm_wdat`=0, `cycles`=0.
- `busy` is a registered-state decode. It rises the cycle after `start` is accepted.
- Byte handshake: transfer occurs when `in_valid` && `in_ready` at a clock edge. DMem commits the write on that same edge (zero latency). Throughput is one byte per cycle. `in_valid` may drop between bytes with no penalty.
- `core_reset` is a state decode. It deasserts on the first RUN cycle, so the core executes PC=0 in that cycle.
- `core_done` is sampled only in RUN, on the registered edge.
- `finished` rises exactly one cycle after the RUN cycle in which `core_done` or timeout is observed.
- Minimum session latency for `load_len`=0 with `core_done` on the first RUN cycle: 1 + `RST_CYCLES` + 1 cycles from `start` to `finished`.

## Structure
- Package `launcher_pkg` holds:
  - `launch_state_t` enum {IDLE, LOAD, CRST, RUN, REPORT};
  - localparams `DM_AW`=8 and `CYC_W`=16.
- Single module with all counters inline. No sub-module needed.
- Integrator responsibilities: add the `dm_*` mux in front of DMem's `Wen`/`Addr`/`WDat`, and replace the core's direct `reset` with `reset | core_reset`.

## Test plan
- **Normal load:** `load_len`=4, bytes 0x11, 0x22, 0x33, 0x44 one per cycle → `dm_wen` on 4 cycles at addresses 0..3; CRST lasts 2 cycles; `core_reset` falls; `core_done` after 10 RUN cycles → `finished` pulse, `cycles`=10, `timeout`=0.
- **Gappy stream:** `load_len`=3, `in_valid` toggled 1-0-1-0-1 → exactly 3 writes at addresses 0, 1, 2; the state stays LOAD until the third accept.
- **Zero-length load:** `load_len`=0 → IDLE→CRST directly, no `dm_wen`. Holding `core_done`=1 during CRST is ignored; `cycles`=0 when it is seen in the first RUN cycle.
- **Timeout:** `TIMEOUT`=8, `core_done` never asserted → `finished` with `timeout`=1 and `cycles`=8. `timeout` clears on the next `start`.
- **Reset and ignored start:** `reset` asserted mid-LOAD after 2 of 5 bytes → next cycle IDLE, `busy`=0, `core_reset`=1, `in_ready`=0. A `start` pulse during RUN is ignored, and `load_len` is not re-latched.
- **Full memory:** `load_len`=256 → 256 writes at addresses 0..255, then a normal CRST/RUN sequence.
